// File: rtl/panel_sequencer.sv
// Front-panel sequencer: run/stop/single-step control, PC/AC load strobes and switch-register deposit.
// Optional build macro PANEL_AUTOINC_EN: pulse pc_inc in the cycle after a successful deposit.
module panel_sequencer #(
  parameter int MEM_TIMEOUT_CYC = 16
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        run,
  input  logic        step,
  input  logic        loadpc,
  input  logic        loadac,
  input  logic        deposit,
  input  logic [11:0] swreg,
  input  logic [1:0]  dispsel,
  input  logic [11:0] pc_in,
  input  logic [11:0] ac_in,
  input  logic [11:0] mb_in,
  input  logic        link_in,
  input  logic        cpu_busy,
  input  logic        cpu_done,
  input  logic        cpu_hlt,
  input  logic        mem_ack,
  output logic        halt,
  output logic [11:0] dispout,
  output logic        linkout,
  output logic        cpu_go,
  output logic        pc_ld,
  output logic        ac_ld,
  output logic        pc_inc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [11:0] mem_wdata,
  output logic        dep_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STOP_PEND = 3'd2,
    STEP_EXEC = 3'd3,
    STEP_WAIT = 3'd4,
    DEP_WAIT  = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             pc_ld_r, pc_ld_s, ac_ld_r, ac_ld_s, pc_inc_r, pc_inc_s;
  logic             halt_r, halt_s, dep_err_r, dep_err_s, capture_s;
  logic             cpu_go_r, mem_req_r, linkout_r;
  logic [11:0]      mem_addr_r, mem_wdata_r, dispout_r, disp_s;

  assign halt      = halt_r;
  assign dispout   = dispout_r;
  assign linkout   = linkout_r;
  assign cpu_go    = cpu_go_r;
  assign pc_ld     = pc_ld_r;
  assign ac_ld     = ac_ld_r;
  assign pc_inc    = pc_inc_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_req_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign dep_err   = dep_err_r;

  // Next-state, one-shot strobes and deposit timeout bookkeeping
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    pc_ld_s   = 1'b0;
    ac_ld_s   = 1'b0;
    pc_inc_s  = 1'b0;
    halt_s    = 1'b0;
    dep_err_s = dep_err_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (run) begin
          state_s = RUN;
        end else if (loadpc) begin
          pc_ld_s   = 1'b1;
          dep_err_s = 1'b0;
        end else if (loadac) begin
          ac_ld_s   = 1'b1;
          dep_err_s = 1'b0;
        end else if (deposit) begin
          state_s   = DEP_WAIT;
          capture_s = 1'b1;
          cnt_s     = '0;
          dep_err_s = 1'b0;
        end else if (step) begin
          state_s   = STEP_EXEC;
          dep_err_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // A HLT beats a simultaneous run drop: the CPU has already stopped itself.
        if (cpu_hlt) begin
          state_s = IDLE;
          halt_s  = 1'b1;
        end else if (!run) begin
          if (cpu_busy) begin
            state_s = STOP_PEND;
          end else begin
            state_s = IDLE;
            halt_s  = 1'b1;
          end
        end else begin
          state_s = RUN;
        end
      end
      STOP_PEND, STEP_WAIT: begin
        if (cpu_done) begin
          state_s = IDLE;
          halt_s  = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      STEP_EXEC: begin
        state_s = STEP_WAIT;
      end
      DEP_WAIT: begin
        if (mem_ack) begin
          state_s = IDLE;
`ifdef PANEL_AUTOINC_EN
          pc_inc_s = 1'b1;
`else
          pc_inc_s = 1'b0;
`endif
        end else if (cnt_r == CNT_LAST) begin
          state_s   = IDLE;
          dep_err_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Display word selection
  always_comb begin
    disp_s = 12'o0000;
    case (dispsel)
      2'b00:   disp_s = pc_in;
      2'b01:   disp_s = ac_in;
      2'b10:   disp_s = mb_in;
      2'b11:   disp_s = swreg;
      default: disp_s = 12'o0000;
    endcase
  end

  // State and registered outputs; levels are decoded from the state being entered
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      pc_ld_r     <= 1'b0;
      ac_ld_r     <= 1'b0;
      pc_inc_r    <= 1'b0;
      halt_r      <= 1'b0;
      dep_err_r   <= 1'b0;
      cpu_go_r    <= 1'b0;
      mem_req_r   <= 1'b0;
      linkout_r   <= 1'b0;
      mem_addr_r  <= 12'o0000;
      mem_wdata_r <= 12'o0000;
      dispout_r   <= 12'o0000;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pc_ld_r   <= pc_ld_s;
      ac_ld_r   <= ac_ld_s;
      pc_inc_r  <= pc_inc_s;
      halt_r    <= halt_s;
      dep_err_r <= dep_err_s;
      cpu_go_r  <= (state_s == RUN) || (state_s == STEP_EXEC);
      mem_req_r <= (state_s == DEP_WAIT);
      linkout_r <= link_in;
      dispout_r <= disp_s;
      if (capture_s) begin
        mem_addr_r  <= pc_in;
        mem_wdata_r <= swreg;
      end else begin
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
    end
  end

endmodule

// File: tb/tb_panel_sequencer.sv
// Directed bench for panel_sequencer: a flag-based panel model checked every cycle, plus literal pins.
module tb_panel_sequencer;

  localparam int TMO = 16;
`ifdef PANEL_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clock, resetN, run, step, loadpc, loadac, deposit;
  logic [11:0] swreg, pc_in, ac_in, mb_in;
  logic [1:0] dispsel;
  logic link_in, cpu_busy, cpu_done, cpu_hlt, mem_ack;
  logic halt, linkout, cpu_go, pc_ld, ac_ld, pc_inc, mem_req, mem_we, dep_err;
  logic [11:0] dispout, mem_addr, mem_wdata;

  int n_pass = 0;
  int n_total = 0;

  panel_sequencer #(.MEM_TIMEOUT_CYC(TMO)) dut (
    .clock(clock), .resetN(resetN), .run(run), .step(step), .loadpc(loadpc),
    .loadac(loadac), .deposit(deposit), .swreg(swreg), .dispsel(dispsel),
    .pc_in(pc_in), .ac_in(ac_in), .mb_in(mb_in), .link_in(link_in),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_hlt(cpu_hlt), .mem_ack(mem_ack),
    .halt(halt), .dispout(dispout), .linkout(linkout), .cpu_go(cpu_go),
    .pc_ld(pc_ld), .ac_ld(ac_ld), .pc_inc(pc_inc), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dep_err(dep_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %o, expected %o", name, $time, act, exp);
  endtask

  // Panel model: activity flags rather than a state code
  logic running, stopping, step_go, step_wait, dep_active;
  int   dep_cycles;
  logic e_pc_ld, e_ac_ld, e_halt, e_inc, e_derr, e_link;
  logic [11:0] e_addr, e_wdata, e_disp;

  function automatic logic [11:0] panel_word(input logic [1:0] s);
    logic [11:0] w [4];
    w[0] = pc_in; w[1] = ac_in; w[2] = mb_in; w[3] = swreg;
    return w[s];
  endfunction

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      running <= 1'b0; stopping <= 1'b0; step_go <= 1'b0; step_wait <= 1'b0;
      dep_active <= 1'b0; dep_cycles <= 0;
      e_pc_ld <= 1'b0; e_ac_ld <= 1'b0; e_halt <= 1'b0; e_inc <= 1'b0;
      e_derr <= 1'b0; e_link <= 1'b0;
      e_addr <= 12'o0000; e_wdata <= 12'o0000; e_disp <= 12'o0000;
    end else begin
      e_pc_ld <= 1'b0; e_ac_ld <= 1'b0; e_halt <= 1'b0; e_inc <= 1'b0;
      e_link <= link_in;
      e_disp <= panel_word(dispsel);
      if (!(running || stopping || step_go || step_wait || dep_active)) begin
        if (run) running <= 1'b1;
        else if (loadpc) begin e_pc_ld <= 1'b1; e_derr <= 1'b0; end
        else if (loadac) begin e_ac_ld <= 1'b1; e_derr <= 1'b0; end
        else if (deposit) begin
          dep_active <= 1'b1; dep_cycles <= 0;
          e_addr <= pc_in; e_wdata <= swreg; e_derr <= 1'b0;
        end
        else if (step) begin step_go <= 1'b1; e_derr <= 1'b0; end
      end else if (running) begin
        if (cpu_hlt) begin running <= 1'b0; e_halt <= 1'b1; end
        else if (!run) begin
          running <= 1'b0;
          if (cpu_busy) stopping <= 1'b1;
          else e_halt <= 1'b1;
        end
      end else if (stopping) begin
        if (cpu_done) begin stopping <= 1'b0; e_halt <= 1'b1; end
      end else if (step_go) begin
        step_go <= 1'b0; step_wait <= 1'b1;
      end else if (step_wait) begin
        if (cpu_done) begin step_wait <= 1'b0; e_halt <= 1'b1; end
      end else begin
        if (mem_ack) begin dep_active <= 1'b0; e_inc <= AUTO; end
        else if (dep_cycles + 1 == TMO) begin dep_active <= 1'b0; e_derr <= 1'b1; end
        else dep_cycles <= dep_cycles + 1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    chk("halt", {11'd0, halt}, {11'd0, e_halt});
    chk("cpu_go", {11'd0, cpu_go}, {11'd0, running | step_go});
    chk("pc_ld", {11'd0, pc_ld}, {11'd0, e_pc_ld});
    chk("ac_ld", {11'd0, ac_ld}, {11'd0, e_ac_ld});
    chk("pc_inc", {11'd0, pc_inc}, {11'd0, e_inc});
    chk("mem_req", {11'd0, mem_req}, {11'd0, dep_active});
    chk("mem_we", {11'd0, mem_we}, {11'd0, dep_active});
    chk("dep_err", {11'd0, dep_err}, {11'd0, e_derr});
    chk("linkout", {11'd0, linkout}, {11'd0, e_link});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("dispout", dispout, e_disp);
  end

  task automatic tick();
    @(posedge clock);
    #2;
    step = 1'b0; loadpc = 1'b0; loadac = 1'b0; deposit = 1'b0;
    cpu_done = 1'b0; cpu_hlt = 1'b0; mem_ack = 1'b0;
  endtask

  logic [11:0] disp_tab [4];
  int n;

  initial begin
    resetN = 1'b0; run = 1'b0; step = 1'b0; loadpc = 1'b0; loadac = 1'b0; deposit = 1'b0;
    swreg = 12'o0000; dispsel = 2'b00; pc_in = 12'o0000; ac_in = 12'o0000; mb_in = 12'o0000;
    link_in = 1'b0; cpu_busy = 1'b0; cpu_done = 1'b0; cpu_hlt = 1'b0; mem_ack = 1'b0;
    disp_tab[0] = 12'o1234; disp_tab[1] = 12'o5670; disp_tab[2] = 12'o0017; disp_tab[3] = 12'o7777;

    // reset state
    pc_in = 12'o4321; link_in = 1'b1;
    tick(); tick();
    @(negedge clock);
    chk("rst_dispout", dispout, 12'o0000);
    chk("rst_linkout", {11'd0, linkout}, 12'd0);
    chk("rst_cpu_go", {11'd0, cpu_go}, 12'd0);
    resetN = 1'b1;
    tick(); tick();

    // loadpc, then loadac+step together
    swreg = 12'o0200; loadpc = 1'b1;
    tick();
    @(negedge clock);
    chk("lit_pc_ld", {11'd0, pc_ld}, 12'd1);
    loadac = 1'b1; step = 1'b1;
    tick();
    @(negedge clock);
    chk("lit_ac_ld", {11'd0, ac_ld}, 12'd1);
    chk("lit_pc_ld_off", {11'd0, pc_ld}, 12'd0);
    chk("lit_no_step", {11'd0, cpu_go}, 12'd0);
    tick();

    // deposit with ack three cycles later
    pc_in = 12'o0200; swreg = 12'o7402; link_in = 1'b0; deposit = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (mem_req) n++;
      if (i == 2) mem_ack = 1'b1;
      tick();
    end
    @(negedge clock);
    chk("lit_dep_addr", mem_addr, 12'o0200);
    chk("lit_dep_wdata", mem_wdata, 12'o7402);
    chk("lit_req_len", 12'(n), 12'd3);
    chk("lit_req_off", {11'd0, mem_req}, 12'd0);
    chk("lit_pc_inc", {11'd0, pc_inc}, {11'd0, AUTO});
    tick();

    // deposit timeout, cleared by the next loadpc
    deposit = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mem_req) n++;
      tick();
    end
    @(negedge clock);
    chk("lit_tmo_len", 12'(n), 12'd16);
    chk("lit_dep_err", {11'd0, dep_err}, 12'd1);
    chk("lit_tmo_inc", {11'd0, pc_inc}, 12'd0);
    loadpc = 1'b1;
    tick();
    @(negedge clock);
    chk("lit_dep_err_clr", {11'd0, dep_err}, 12'd0);

    // run, drop run while busy, done five cycles later
    run = 1'b1; cpu_busy = 1'b1; link_in = 1'b1;
    tick(); loadpc = 1'b1; tick();
    @(negedge clock);
    chk("lit_run_go", {11'd0, cpu_go}, 12'd1);
    chk("lit_run_ignore", {11'd0, pc_ld}, 12'd0);
    run = 1'b0;
    tick();
    @(negedge clock);
    chk("lit_stop_go", {11'd0, cpu_go}, 12'd0);
    chk("lit_stop_halt", {11'd0, halt}, 12'd0);
    tick(); tick(); tick(); tick();
    cpu_done = 1'b1; cpu_busy = 1'b0;
    tick();
    @(negedge clock);
    chk("lit_stop_halt2", {11'd0, halt}, 12'd1);
    tick();

    // run dropped while idle CPU: immediate halt
    run = 1'b1; tick(); tick();
    run = 1'b0; tick();
    @(negedge clock);
    chk("lit_fast_halt", {11'd0, halt}, 12'd1);

    // single step
    step = 1'b1;
    tick();
    @(negedge clock);
    chk("lit_step_go", {11'd0, cpu_go}, 12'd1);
    tick();
    @(negedge clock);
    chk("lit_step_go_off", {11'd0, cpu_go}, 12'd0);
    tick();
    cpu_done = 1'b1;
    tick();
    @(negedge clock);
    chk("lit_step_halt", {11'd0, halt}, 12'd1);
    tick();

    // HLT in RUN, and HLT beating run=0 with busy CPU
    run = 1'b1; tick(); tick();
    cpu_hlt = 1'b1; run = 1'b0; cpu_busy = 1'b1;
    tick();
    @(negedge clock);
    chk("lit_hlt_halt", {11'd0, halt}, 12'd1);
    chk("lit_hlt_go", {11'd0, cpu_go}, 12'd0);
    cpu_busy = 1'b0; loadac = 1'b1;
    tick();
    @(negedge clock);
    chk("lit_hlt_idle", {11'd0, ac_ld}, 12'd1);
    run = 1'b1; tick(); tick();
    cpu_hlt = 1'b1;
    tick();
    run = 1'b0;
    tick();

    // display sweep
    pc_in = 12'o1234; ac_in = 12'o5670; mb_in = 12'o0017; swreg = 12'o7777;
    for (int s = 0; s < 4; s++) begin
      dispsel = 2'(s);
      tick();
      @(negedge clock);
      chk("lit_disp", dispout, disp_tab[s]);
    end

    // PC of 7777 passes through untouched
    pc_in = 12'o7777; dispsel = 2'b00; swreg = 12'o0055; deposit = 1'b1;
    tick();
    mem_ack = 1'b1;
    tick();
    @(negedge clock);
    chk("lit_pc7777_disp", dispout, 12'o7777);
    chk("lit_pc7777_addr", mem_addr, 12'o7777);
    tick();

    // reset mid-step
    step = 1'b1;
    tick();
    #1 resetN = 1'b0;
    #1 chk("lit_rst_step_go", {11'd0, cpu_go}, 12'd0);
    @(negedge clock); resetN = 1'b1;
    cpu_done = 1'b1;
    tick();
    @(negedge clock);
    chk("lit_rst_step_halt", {11'd0, halt}, 12'd0);

    // reset mid-deposit
    deposit = 1'b1;
    tick(); tick();
    #1 resetN = 1'b0;
    #1 chk("lit_rst_dep_req", {11'd0, mem_req}, 12'd0);
    @(negedge clock); resetN = 1'b1;
    mem_ack = 1'b1;
    tick();
    @(negedge clock);
    chk("lit_rst_dep_inc", {11'd0, pc_inc}, 12'd0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
